// File: rtl/ib_ram_bank_sched.sv
// Ping-pong scheduler for the two inbound packet RAM banks. The DMA stream writer fills one bank
// while the IPSec core reads the other. Packets longer than a bank are truncated, and the rest is dropped.
module ib_ram_bank_sched #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          s_tvalid,
    input  logic          s_tlast,
    output logic          s_tready,
    output logic          ram_we,
    output logic          ram_wbank,
    output logic [AW-1:0] ram_waddr,
    output logic          pkt_valid,
    output logic          pkt_bank,
    output logic [AW:0]   pkt_len,
    input  logic          pkt_start,
    input  logic          pkt_done,
    output logic          ovf_err,
    input  logic          ovf_clr,
    output logic [15:0]   drop_cnt
);
    typedef enum logic [1:0] {EMPTY, FILLING, FULL, READING} bank_state_t;

    logic          wr_sel_reg;
    logic          rd_sel_reg;
    logic [AW-1:0] wr_addr_reg;
    logic          drop_reg;
    logic          ovf_err_reg;
    logic [15:0]   drop_cnt_reg;

    bank_state_t   wr_state;
    bank_state_t   rd_state;
    logic          accept;
    logic          wr_beat;
    logic          at_end;
    logic          close;
    logic          overflow;
    logic          rd_claim;
    logic          rd_free;

    // Each bank runs its own small state machine; the selectors decide which event reaches it.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_bank
            bank_state_t state_reg;
            bank_state_t state_next;
            logic [AW:0] len_reg;

            always_comb begin
                state_next = state_reg;
                if (wr_beat && wr_sel_reg == 1'(gi)) begin
                    state_next = close ? FULL : FILLING;
                end else if (rd_sel_reg == 1'(gi)) begin
                    if (rd_free) begin
                        state_next = EMPTY;
                    end else if (rd_claim) begin
                        state_next = READING;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    state_reg <= EMPTY;
                    len_reg   <= '0;
                end else begin
                    state_reg <= state_next;
                    if (close && wr_sel_reg == 1'(gi)) begin
                        len_reg <= {1'b0, wr_addr_reg} + (AW+1)'(1);
                    end
                end
            end
        end
    endgenerate

    assign wr_state = wr_sel_reg ? g_bank[1].state_reg : g_bank[0].state_reg;
    assign rd_state = rd_sel_reg ? g_bank[1].state_reg : g_bank[0].state_reg;

    // Ready depends only on registered state plus en/rst, never on s_tvalid.
    assign s_tready = !rst && (drop_reg || wr_state == FILLING || (wr_state == EMPTY && en));
    assign accept   = s_tvalid && s_tready;
    assign wr_beat  = accept && !drop_reg;
    assign at_end   = (wr_addr_reg == AW'(DEPTH - 1));
    assign close    = wr_beat && (s_tlast || at_end);
    assign overflow = wr_beat && !s_tlast && at_end;
    assign rd_claim = pkt_start && rd_state == FULL;
    assign rd_free  = pkt_done && rd_state == READING;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_sel_reg   <= 1'b0;
            rd_sel_reg   <= 1'b0;
            wr_addr_reg  <= '0;
            drop_reg     <= 1'b0;
            ovf_err_reg  <= 1'b0;
            drop_cnt_reg <= '0;
        end else begin
            if (close) begin
                wr_addr_reg <= '0;
                wr_sel_reg  <= ~wr_sel_reg;
            end else if (wr_beat) begin
                wr_addr_reg <= wr_addr_reg + AW'(1);
            end
            if (rd_free) begin
                rd_sel_reg <= ~rd_sel_reg;
            end
            if (overflow) begin
                drop_reg <= 1'b1;
            end else if (accept && drop_reg && s_tlast) begin
                drop_reg <= 1'b0;
            end
            // A new overflow takes priority over a simultaneous clear.
            if (overflow) begin
                ovf_err_reg <= 1'b1;
            end else if (ovf_clr) begin
                ovf_err_reg <= 1'b0;
            end
            if (overflow && drop_cnt_reg != 16'hFFFF) begin
                drop_cnt_reg <= drop_cnt_reg + 16'd1;
            end
        end
    end

    assign ram_we    = wr_beat;
    assign ram_wbank = wr_sel_reg;
    assign ram_waddr = wr_addr_reg;
    assign pkt_valid = (rd_state == FULL);
    assign pkt_bank  = rd_sel_reg;
    assign pkt_len   = rd_sel_reg ? g_bank[1].len_reg : g_bank[0].len_reg;
    assign ovf_err   = ovf_err_reg;
    assign drop_cnt  = drop_cnt_reg;

endmodule

// File: tb/tb_ib_ram_bank_sched.sv
// Bench for ib_ram_bank_sched. A packet-level model tracks the pending packet queue, the fill count
// and the drop mode, and checks every output on every cycle of the directed and random stimulus.
module tb_ib_ram_bank_sched;
    localparam int DEPTH = 64;
    localparam int AW    = 6;

    logic          clk = 1'b0;
    logic          rst, en, s_tvalid, s_tlast, s_tready;
    logic          ram_we, ram_wbank;
    logic [AW-1:0] ram_waddr;
    logic          pkt_valid, pkt_bank;
    logic [AW:0]   pkt_len;
    logic          pkt_start, pkt_done, ovf_err, ovf_clr;
    logic [15:0]   drop_cnt;

    always #5 clk = ~clk;

    ib_ram_bank_sched #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .en(en), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
        .s_tready(s_tready), .ram_we(ram_we), .ram_wbank(ram_wbank), .ram_waddr(ram_waddr),
        .pkt_valid(pkt_valid), .pkt_bank(pkt_bank), .pkt_len(pkt_len),
        .pkt_start(pkt_start), .pkt_done(pkt_done), .ovf_err(ovf_err), .ovf_clr(ovf_clr),
        .drop_cnt(drop_cnt)
    );

    int checks = 0;
    int errors = 0;

    // Packet-level model: queue of finished packet lengths; the front one is offered or being read.
    int len_q[$];
    bit claimed;
    int closed_cnt, freed_cnt, beats;
    bit in_pkt, dropping, m_ovf;
    int m_drop;
    int we_cnt, acc_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        len_q.delete();
        claimed = 0; closed_cnt = 0; freed_cnt = 0; beats = 0;
        in_pkt = 0; dropping = 0; m_ovf = 0; m_drop = 0;
    endtask

    task automatic step(input bit e, input bit v, input bit l, input bit st, input bit dn,
                        input bit clr, input bit r);
        bit exp_rdy, acc, exp_we, have_pkt, ovf_now;
        @(negedge clk);
        rst = r; en = e; s_tvalid = v; s_tlast = l; pkt_start = st; pkt_done = dn; ovf_clr = clr;
        #1;
        exp_rdy  = !r && (dropping || in_pkt || (len_q.size() < 2 && e));
        acc      = v && exp_rdy;
        exp_we   = acc && !dropping;
        have_pkt = (len_q.size() > 0) && !claimed;
        check("s_tready", 32'(s_tready), 32'(exp_rdy));
        check("ram_we", 32'(ram_we), 32'(exp_we));
        if (exp_we) check("ram_wbank", 32'(ram_wbank), 32'(closed_cnt % 2));
        check("ram_waddr", 32'(ram_waddr), 32'(beats));
        check("pkt_valid", 32'(pkt_valid), 32'(have_pkt));
        check("pkt_bank", 32'(pkt_bank), 32'(freed_cnt % 2));
        if (have_pkt) check("pkt_len", 32'(pkt_len), 32'(len_q[0]));
        check("ovf_err", 32'(ovf_err), 32'(m_ovf));
        check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
        if (exp_we) we_cnt++;
        if (acc) acc_cnt++;
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            ovf_now = 0;
            if (dn && claimed) begin
                void'(len_q.pop_front());
                claimed = 0;
                freed_cnt++;
            end else if (st && have_pkt) begin
                claimed = 1;
            end
            if (acc) begin
                if (dropping) begin
                    if (l) dropping = 0;
                end else begin
                    beats++;
                    if (l || beats == DEPTH) begin
                        len_q.push_back(beats);
                        closed_cnt++;
                        beats  = 0;
                        in_pkt = 0;
                        if (!l) begin
                            ovf_now  = 1;
                            dropping = 1;
                            if (m_drop < 65535) m_drop++;
                        end
                    end else begin
                        in_pkt = 1;
                    end
                end
            end
            if (ovf_now) m_ovf = 1;
            else if (clr) m_ovf = 0;
        end
    endtask

    task automatic send_pkt(input int n);
        for (int i = 0; i < n; i++) step(1, 1, i == n - 1, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1; en = 0; s_tvalid = 0; s_tlast = 0; pkt_start = 0; pkt_done = 0; ovf_clr = 0;
        repeat (2) @(posedge clk);
        model_reset();

        // T1 basic 5-beat packet
        step(0, 0, 0, 0, 0, 0, 1);
        send_pkt(5);
        #1;
        check("T1_pkt_valid", 32'(pkt_valid), 32'd1);
        check("T1_pkt_bank", 32'(pkt_bank), 32'd0);
        check("T1_pkt_len", 32'(pkt_len), 32'd5);

        // T2 both banks full stall, then release
        step(0, 0, 0, 0, 0, 0, 1);
        send_pkt(3);
        send_pkt(3);
        step(1, 1, 0, 0, 0, 0, 0);
        #1 check("T2_stall", 32'(s_tready), 32'd0);
        step(1, 0, 0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 1, 0, 0);
        #1;
        check("T2_ready", 32'(s_tready), 32'd1);
        check("T2_pkt_bank", 32'(pkt_bank), 32'd1);
        check("T2_pkt_len", 32'(pkt_len), 32'd3);

        // T3 overflow: 70 beats into a 64-word bank
        step(0, 0, 0, 0, 0, 0, 1);
        we_cnt = 0; acc_cnt = 0;
        send_pkt(70);
        #1;
        check("T3_writes", 32'(we_cnt), 32'd64);
        check("T3_dropped", 32'(acc_cnt - we_cnt), 32'd6);
        check("T3_pkt_len", 32'(pkt_len), 32'd64);
        check("T3_ovf_err", 32'(ovf_err), 32'd1);
        check("T3_drop_cnt", 32'(drop_cnt), 32'd1);
        step(0, 0, 0, 0, 0, 1, 0);
        #1 check("T3_ovf_clr", 32'(ovf_err), 32'd0);

        // T4 exact fill is not an overflow
        step(0, 0, 0, 0, 0, 0, 1);
        send_pkt(64);
        #1;
        check("T4_pkt_len", 32'(pkt_len), 32'd64);
        check("T4_ovf_err", 32'(ovf_err), 32'd0);
        check("T4_drop_cnt", 32'(drop_cnt), 32'd0);

        // T5 en gating at boundary, ignored mid-packet
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0, 0);
        #1;
        check("T5_pkt_valid", 32'(pkt_valid), 32'd1);
        check("T5_pkt_len", 32'(pkt_len), 32'd3);

        // T6 close on bank 1 with done on bank 0, then reset mid-packet
        step(0, 0, 0, 0, 0, 0, 1);
        send_pkt(2);
        step(1, 0, 0, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0);
        step(1, 1, 1, 0, 1, 0, 0);
        #1;
        check("T6_pkt_valid", 32'(pkt_valid), 32'd1);
        check("T6_pkt_bank", 32'(pkt_bank), 32'd1);
        check("T6_pkt_len", 32'(pkt_len), 32'd2);
        step(1, 1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 1);
        #1;
        check("T6_rst_valid", 32'(pkt_valid), 32'd0);
        check("T6_rst_waddr", 32'(ram_waddr), 32'd0);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            step($urandom % 8 != 0, $urandom % 4 != 0, $urandom % 30 == 0,
                 $urandom % 6 == 0, $urandom % 6 == 0, $urandom % 50 == 0,
                 $urandom % 1500 == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
